// File: rtl/fscpu_arb_pkg.sv
// fscpu_arb_pkg: shared FSM states, timeout status code and default widths for the fscpu request arbiter
package fscpu_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    localparam logic [31:0] ERR_TIMEOUT = 32'hFFFF_FFFF;
    localparam int CMD_W   = 32;
    localparam int PARAM_W = 128;
    localparam int TMO_W   = 32;
endpackage

// File: rtl/fscpu_rr_arb2.sv
// fscpu_rr_arb2: 2-way round-robin grant
// valid[1:0] requests; ptr = requester holding priority; grant[1:0] one-hot (or zero when nothing is valid)
module fscpu_rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);
    assign grant[0] = valid[0] & (~ptr | ~valid[1]);
    assign grant[1] = valid[1] & (ptr | ~valid[0]);
endmodule

// File: rtl/fscpu_req_arbiter.sv
// fscpu_req_arbiter: round-robin arbitration of two command requesters onto a single fscpu request port
// clk/resetn: clock, async active-low reset
// s0_*/s1_*: requester ports (valid/ready accept, cmd/param, done pulse with err status)
// req_*: fscpu side (req_en strobe, cmd/param, req_done/req_err completion)
// timeout_cycles: WAIT limit, 0 disables; busy: not IDLE; owner: requester being served
module fscpu_req_arbiter
    import fscpu_arb_pkg::*;
#(
    parameter int C_CMD_WIDTH   = CMD_W,
    parameter int C_PARAM_WIDTH = PARAM_W,
    parameter int C_TMO_WIDTH   = TMO_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     s0_valid,
    output logic                     s0_ready,
    input  logic [C_CMD_WIDTH-1:0]   s0_cmd,
    input  logic [C_PARAM_WIDTH-1:0] s0_param,
    output logic                     s0_done,
    output logic [31:0]              s0_err,
    input  logic                     s1_valid,
    output logic                     s1_ready,
    input  logic [C_CMD_WIDTH-1:0]   s1_cmd,
    input  logic [C_PARAM_WIDTH-1:0] s1_param,
    output logic                     s1_done,
    output logic [31:0]              s1_err,
    output logic                     req_en,
    output logic [C_CMD_WIDTH-1:0]   req_cmd,
    output logic [C_PARAM_WIDTH-1:0] req_param,
    input  logic                     req_done,
    input  logic [31:0]              req_err,
    input  logic [C_TMO_WIDTH-1:0]   timeout_cycles,
    output logic                     busy,
    output logic                     owner
);
    localparam logic [C_TMO_WIDTH-1:0] TMO_ONE = 1;
    state_t                 state;
    logic                   rr_ptr;
    logic [C_TMO_WIDTH-1:0] timer;
    logic [1:0]             grant;
    logic                   tmo_hit;
    logic [31:0]            fin_err;

    fscpu_rr_arb2 u_rr (
        .valid ({s1_valid, s0_valid}),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign s0_ready = (state == IDLE) & grant[0];
    assign s1_ready = (state == IDLE) & grant[1];
    assign busy     = state != IDLE;
    // timer counts WAIT cycles from 0, so the limit is reached at timeout_cycles-1
    assign tmo_hit  = (timeout_cycles != '0) && (timer == timeout_cycles - TMO_ONE);
    // a completion in the timeout cycle takes precedence over the timeout
    assign fin_err  = req_done ? req_err : ERR_TIMEOUT;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            owner     <= 1'b0;
            req_en    <= 1'b0;
            req_cmd   <= '0;
            req_param <= '0;
            s0_done   <= 1'b0;
            s1_done   <= 1'b0;
            s0_err    <= '0;
            s1_err    <= '0;
            timer     <= '0;
        end else begin
            req_en  <= 1'b0;
            s0_done <= 1'b0;
            s1_done <= 1'b0;
            case (state)
                IDLE: if (|grant) begin
                    req_cmd   <= grant[1] ? s1_cmd : s0_cmd;
                    req_param <= grant[1] ? s1_param : s0_param;
                    owner     <= grant[1];
                    req_en    <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= &timer ? timer : timer + TMO_ONE;
                    if (req_done || tmo_hit) begin
                        s0_done <= ~owner;
                        s1_done <= owner;
                        s0_err  <= owner ? s0_err : fin_err;
                        s1_err  <= owner ? fin_err : s1_err;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr <= ~owner;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fscpu_req_arbiter.sv
// tb_fscpu_req_arbiter: table-driven transactions plus hand-written reset/stray-done sequences
module tb_fscpu_req_arbiter;
    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         s0_valid = 1'b0, s1_valid = 1'b0;
    logic         s0_ready, s1_ready, s0_done, s1_done;
    logic [31:0]  s0_cmd = '0, s1_cmd = '0;
    logic [127:0] s0_param = '0, s1_param = '0;
    logic [31:0]  s0_err, s1_err;
    logic         req_en, req_done = 1'b0, busy, owner;
    logic [31:0]  req_cmd, req_err = '0, timeout_cycles = '0;
    logic [127:0] req_param;

    int checks = 0;
    int errors = 0;
    logic [31:0] err_m [2];

    typedef struct {
        bit           v0;
        bit           v1;
        logic [31:0]  c0;
        logic [31:0]  c1;
        logic [127:0] p0;
        int           done_at;
        logic [31:0]  err_in;
        logic [31:0]  tmo;
        bit           own;
        int           exp_n;
        logic [31:0]  exp_err;
    } vec_t;

    vec_t vecs [10];

    fscpu_req_arbiter dut (
        .clk(clk), .resetn(resetn),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_cmd(s0_cmd), .s0_param(s0_param),
        .s0_done(s0_done), .s0_err(s0_err),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_cmd(s1_cmd), .s1_param(s1_param),
        .s1_done(s1_done), .s1_err(s1_err),
        .req_en(req_en), .req_cmd(req_cmd), .req_param(req_param),
        .req_done(req_done), .req_err(req_err), .timeout_cycles(timeout_cycles),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int n = 0;
        bit got = 0;
        bit bad = 0;
        s0_valid = v.v0; s1_valid = v.v1;
        s0_cmd = v.c0; s1_cmd = v.c1;
        s0_param = v.p0; s1_param = {4{v.c1}};
        timeout_cycles = v.tmo;
        #1;
        chk({tag, ".ready"}, {s1_ready, s0_ready}, v.own ? 2'b10 : 2'b01);
        tick();
        chk({tag, ".req_en"}, req_en, 1'b1);
        chk({tag, ".req_cmd"}, req_cmd, v.own ? v.c1 : v.c0);
        chk({tag, ".req_param"}, req_param, v.own ? {4{v.c1}} : v.p0);
        chk({tag, ".owner"}, owner, v.own);
        chk({tag, ".busy"}, busy, 1'b1);
        tick();
        while (!got && n < 64) begin
            req_done = (n == v.done_at);
            req_err = v.err_in;
            bad |= req_en | s0_ready | s1_ready | s0_done | s1_done;
            tick();
            req_done = 1'b0;
            n++;
            got = s0_done | s1_done;
        end
        chk({tag, ".wait_quiet"}, bad, 1'b0);
        chk({tag, ".latency"}, n, v.exp_n);
        chk({tag, ".done"}, {s1_done, s0_done}, v.own ? 2'b10 : 2'b01);
        chk({tag, ".err"}, v.own ? s1_err : s0_err, v.exp_err);
        chk({tag, ".other_err"}, v.own ? s0_err : s1_err, err_m[!v.own]);
        s0_valid = 1'b0; s1_valid = 1'b0;
        tick();
        chk({tag, ".idle_busy"}, busy, 1'b0);
        chk({tag, ".idle_done"}, {s1_done, s0_done}, 2'b00);
        err_m[v.own] = v.exp_err;
    endtask

    initial begin
        bit bad;
        err_m[0] = '0; err_m[1] = '0;
        vecs[0] = '{1, 1, 32'h11, 32'h21, 128'h1,     2,  32'hA0,   32'd0,  0, 3,  32'hA0};
        vecs[1] = '{1, 1, 32'h12, 32'h22, 128'h2,     1,  32'hA1,   32'd0,  1, 2,  32'hA1};
        vecs[2] = '{1, 1, 32'h13, 32'h23, 128'h3,     0,  32'hA2,   32'd0,  0, 1,  32'hA2};
        vecs[3] = '{1, 0, 32'd29, 32'h0,  128'h12C00, 4,  32'h0,    32'd0,  0, 5,  32'h0};
        vecs[4] = '{1, 0, 32'h5,  32'h0,  128'h5,     -1, 32'h0,    32'd10, 0, 10, 32'hFFFF_FFFF};
        vecs[5] = '{1, 0, 32'h6,  32'h0,  128'h6,     9,  32'h7,    32'd10, 0, 10, 32'h7};
        vecs[6] = '{0, 1, 32'h0,  32'h33, 128'h0,     -1, 32'h0,    32'd1,  1, 1,  32'hFFFF_FFFF};
        vecs[7] = '{0, 1, 32'h0,  32'h34, 128'h0,     20, 32'h55,   32'd0,  1, 21, 32'h55};
        vecs[8] = '{1, 1, 32'h15, 32'h35, 128'h9,     3,  32'h9,    32'd3,  0, 3,  32'hFFFF_FFFF};
        vecs[9] = '{1, 1, 32'h16, 32'h36, 128'hA,     0,  32'h1234, 32'd0,  1, 1,  32'h1234};

        tick();
        chk("rst.busy", busy, 1'b0);
        chk("rst.req_en", req_en, 1'b0);
        chk("rst.req_cmd", req_cmd, 32'h0);
        chk("rst.errs", {s1_err, s0_err}, 64'h0);
        chk("rst.dones", {s1_done, s0_done}, 2'b00);
        tick();
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        bad = 0;
        req_err = 32'h5;
        for (int i = 0; i < 4; i++) begin
            req_done = 1'b1;
            tick();
            bad |= busy | s0_done | s1_done;
        end
        req_done = 1'b0;
        chk("stray.quiet", bad, 1'b0);
        chk("stray.errs", {s1_err, s0_err}, {err_m[1], err_m[0]});

        s0_valid = 1'b1; s0_cmd = 32'd77; s0_param = 128'h1; timeout_cycles = '0;
        tick();
        s0_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("wrst.in_wait", busy, 1'b1);
        resetn = 1'b0;
        #1;
        chk("wrst.busy", busy, 1'b0);
        chk("wrst.req_cmd", req_cmd, 32'h0);
        chk("wrst.req_param", req_param, 128'h0);
        chk("wrst.owner", owner, 1'b0);
        chk("wrst.errs", {s1_err, s0_err}, 64'h0);
        tick();
        tick();
        resetn = 1'b1;
        err_m[0] = '0; err_m[1] = '0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            req_done = 1'b1;
            tick();
            bad |= busy | s0_done | s1_done | req_en;
        end
        req_done = 1'b0;
        chk("wrst.no_done", bad, 1'b0);
        run_txn('{0, 1, 32'h0, 32'h44, 128'h0, 2, 32'h66, 32'd0, 1, 3, 32'h66}, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
